// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its write decoder.
//   ADDR_W_DEF / DATA_W_DEF : default register specifier and data widths
//   ZERO_IDX                : index of the optional hardwired-zero entry
//   nreg()                  : number of entries for a given specifier width
package regfile_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int ZERO_IDX   = 0;

  function automatic int nreg(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_decoded_decoder.sv
// Parametrised binary-to-one-hot decoder with enable.
// Ports:
//   x  : ADDR_W-bit binary select
//   en : enable; all outputs low when 0
//   z  : 2**ADDR_W one-hot output, z[i] = en & (x == i)
module decoder_param #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      x,
  input  logic                   en,
  output logic [2**ADDR_W-1:0]   z
);

  always_comb begin
    z = '0;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      z[i] = en && (x == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/regfile_decoded.sv
// Register file with one write port and two combinational read ports.
// Write strobes come from decoder_param; entry 0 can be hardwired to zero
// and a same-cycle write can optionally be forwarded to the read ports.
// Ports:
//   clk, reset      : rising-edge clock, async active-high clear of storage
//   we, wa, wd      : write enable, address, data
//   ra1/rd1, ra2/rd2: read address / combinational read data
//   wr_sel          : one-hot write strobe, bit i = register i
module regfile_decoded
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           wa,
  input  logic [DATA_W-1:0]           wd,
  input  logic [ADDR_W-1:0]           ra1,
  input  logic [ADDR_W-1:0]           ra2,
  output logic [DATA_W-1:0]           rd1,
  output logic [DATA_W-1:0]           rd2,
  output logic [nreg(ADDR_W)-1:0]     wr_sel
);

  localparam int NREG = nreg(ADDR_W);

  logic [NREG-1:0]   dec_z;
  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];

  decoder_param #(.ADDR_W(ADDR_W)) u_dec (
    .x  (wa),
    .en (we),
    .z  (dec_z)
  );

  // Masking the zero entry's strobe keeps it at its reset value forever.
  always_comb begin
    wr_sel = dec_z;
    if (ZERO_REG != 0) wr_sel[ZERO_IDX] = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = wr_sel[i] ? wd : mem_q[i];
    end
  end

  // Async clear also swallows any write whose edge lands while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Priority: zero register over bypass over storage. Bypass is gated with
  // reset so the ports read exactly 0 while storage is being cleared.
  always_comb begin
    rd1 = mem_q[ra1];
    if (BYPASS != 0 && we && !reset && wa == ra1) rd1 = wd;
    if (ZERO_REG != 0 && ra1 == ADDR_W'(ZERO_IDX)) rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (BYPASS != 0 && we && !reset && wa == ra2) rd2 = wd;
    if (ZERO_REG != 0 && ra2 == ADDR_W'(ZERO_IDX)) rd2 = '0;
  end

endmodule

// File: tb/tb_regfile_decoded.sv
// Directed bench: instance A uses defaults (5-bit, 32-bit, zero reg, bypass),
// instance B is 3-bit / 8-bit with an ordinary entry 0 and no bypass.
module tb_regfile_decoded;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        we_a;
  logic [4:0]  wa_a, ra1_a, ra2_a;
  logic [31:0] wd_a, rd1_a, rd2_a, wr_sel_a;
  logic        we_b;
  logic [2:0]  wa_b, ra1_b, ra2_b;
  logic [7:0]  wd_b, rd1_b, rd2_b, wr_sel_b;

  regfile_decoded u_a (
    .clk    (clk),
    .reset  (reset),
    .we     (we_a),
    .wa     (wa_a),
    .wd     (wd_a),
    .ra1    (ra1_a),
    .ra2    (ra2_a),
    .rd1    (rd1_a),
    .rd2    (rd2_a),
    .wr_sel (wr_sel_a)
  );

  regfile_decoded #(.ADDR_W(3), .DATA_W(8), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk    (clk),
    .reset  (reset),
    .we     (we_b),
    .wa     (wa_b),
    .wd     (wd_b),
    .ra1    (ra1_b),
    .ra2    (ra2_b),
    .rd1    (rd1_b),
    .rd2    (rd2_b),
    .wr_sel (wr_sel_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  initial begin
    reset = 1'b1;
    we_a = 1'b0; wa_a = '0; wd_a = '0; ra1_a = '0; ra2_a = '0;
    we_b = 1'b0; wa_b = '0; wd_b = '0; ra1_b = '0; ra2_b = '0;
    #1;
    chk("rst_rd1_a", rd1_a, 0);
    chk("rst_rd2_a", rd2_a, 0);
    chk("rst_wrsel_a", wr_sel_a, 0);
    chk("rst_wrsel_b", wr_sel_b, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // basic write/read on defaults
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF; ra1_a = 5'd5; ra2_a = 5'd6;
    #1;
    chk("basic_wrsel", wr_sel_a, 32'h0000_0020);
    chk("basic_bypass", rd1_a, 32'hDEADBEEF);
    @(negedge clk);
    we_a = 1'b0;
    #1;
    chk("basic_rd1", rd1_a, 32'hDEADBEEF);
    chk("basic_rd2", rd2_a, 0);

    // zero register on A, ordinary entry 0 on B
    we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFFFFFF; ra1_a = 5'd0;
    we_b = 1'b1; wa_b = 3'd0; wd_b = 8'hFF; ra1_b = 3'd0;
    #1;
    chk("zero_wrsel_a", wr_sel_a, 0);
    chk("zero_rd1_a_same", rd1_a, 0);
    chk("zero_wrsel_b", wr_sel_b, 8'h01);
    chk("zero_rd1_b_before", rd1_b, 0);
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
    #1;
    chk("zero_rd1_a_after", rd1_a, 0);
    chk("zero_rd1_b_after", rd1_b, 8'hFF);

    // bypass: load 1 into reg 7, then overwrite with 2 while reading it
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h1;
    we_b = 1'b1; wa_b = 3'd7; wd_b = 8'h1;
    @(negedge clk);
    wd_a = 32'h2; ra1_a = 5'd7; ra2_a = 5'd7;
    wd_b = 8'h2;  ra1_b = 3'd7; ra2_b = 3'd7;
    #1;
    chk("byp_rd1_a", rd1_a, 32'h2);
    chk("byp_rd2_a", rd2_a, 32'h2);
    chk("nobyp_rd1_b_before", rd1_b, 8'h1);
    chk("nobyp_rd2_b_before", rd2_b, 8'h1);
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
    #1;
    chk("byp_rd1_a_after", rd1_a, 32'h2);
    chk("nobyp_rd1_b_after", rd1_b, 8'h2);
    chk("nobyp_rd2_b_after", rd2_b, 8'h2);

    // decoder sweep over entries 0..7
    for (int i = 0; i < 8; i++) begin
      we_a = 1'b1; wa_a = 5'(i); wd_a = 32'(i + 16);
      we_b = 1'b1; wa_b = 3'(i); wd_b = 8'(i + 16);
      #1;
      chk($sformatf("sweep_wrsel_a[%0d]", i), wr_sel_a, (i == 0) ? 0 : (64'd1 << i));
      chk($sformatf("sweep_wrsel_b[%0d]", i), wr_sel_b, 64'd1 << i);
      @(negedge clk);
    end
    we_a = 1'b0; we_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra1_a = 5'(i); ra1_b = 3'(i); ra2_b = 3'(7 - i);
      #1;
      chk($sformatf("sweep_rd1_a[%0d]", i), rd1_a, (i == 0) ? 0 : (i + 16));
      chk($sformatf("sweep_rd1_b[%0d]", i), rd1_b, i + 16);
      chk($sformatf("sweep_rd2_b[%0d]", i), rd2_b, 23 - i);
    end

    // asynchronous reset mid-cycle with loaded contents
    @(posedge clk);
    #3;
    ra1_a = 5'd5; ra2_a = 5'd7; ra1_b = 3'd3; ra2_b = 3'd7;
    #1;
    chk("prerst_rd1_a", rd1_a, 21);
    chk("prerst_rd1_b", rd1_b, 19);
    reset = 1'b1;
    #1;
    chk("arst_rd1_a", rd1_a, 0);
    chk("arst_rd2_a", rd2_a, 0);
    chk("arst_rd1_b", rd1_b, 0);
    chk("arst_rd2_b", rd2_b, 0);
    chk("arst_wrsel_a", wr_sel_a, 0);
    we_a = 1'b1; wa_a = 5'd3; wd_a = 32'hAA; ra1_a = 5'd3;
    we_b = 1'b1; wa_b = 3'd3; wd_b = 8'hAA; ra1_b = 3'd3;
    #1;
    chk("rst_byp_gated_a", rd1_a, 0);
    chk("rst_wrsel_a_dec", wr_sel_a, 32'h8);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; we_a = 1'b0; we_b = 1'b0;
    #1;
    chk("rst_wr_lost_a", rd1_a, 0);
    chk("rst_wr_lost_b", rd1_b, 0);
    we_b = 1'b1; wd_b = 8'h55;
    @(negedge clk);
    we_b = 1'b0;
    #1;
    chk("post_rst_wr_b", rd1_b, 8'h55);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_decoded.md
Name: regfile_decoded

Overview:
- Parametrised register file for the single-cycle datapath: NREG = 2**ADDR_W entries of DATA_W bits, one write port and two read ports.
- Write-select is produced by an internal parametrised address decoder with enable. This generalises the fixed 2/3/5-bit decoders to any ADDR_W and adds the storage behind them.
- Optional hardwired-zero register 0 and optional same-cycle write-to-read bypass.
- Sits between instruction decode (register specifiers) and the ALU operand muxes.

Parameters:
- ADDR_W, 5, register specifier width; NREG = 2**ADDR_W; legal 1..6.
- DATA_W, 32, register data width; legal 1..64.
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register.
- BYPASS, 1, 1 = a read of the register being written this cycle returns wd combinationally; 0 = it returns the stored (old) value.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high; clears all storage.
- we, input, 1, write enable for the current cycle.
- wa, input, ADDR_W, write address.
- wd, input, DATA_W, write data.
- ra1, input, ADDR_W, read address port 1.
- ra2, input, ADDR_W, read address port 2.
- rd1, output, DATA_W, read data port 1 (combinational).
- rd2, output, DATA_W, read data port 2 (combinational).
- wr_sel, output, NREG, one-hot write strobe; bit i corresponds to register index i (LSB = index 0), combinational.

Behaviour:
- Decoder: wr_sel[i] = we & (wa == i). At most one bit is set; all zero when we=0. If ZERO_REG=1, wr_sel[0] is forced to 0.
- Storage: on posedge clk, each entry i with wr_sel[i]=1 loads wd; all other entries hold. Write latency is 1 cycle; the value is visible through the storage path from the next cycle.
- Reset: when reset=1, all entries go to 0 immediately, independent of clk. While reset is held, writes are blocked.
- Reset mid-operation: a write whose edge coincides with asserted reset is lost. After deassertion, the first rising edge with we=1 writes normally.
- Outputs during reset: rd1/rd2 = 0 unless BYPASS=1 forwards wd. The bypass term is gated with ~reset, so rd1/rd2 are exactly 0 during reset.
- Reads: rdN = entry[raN], purely combinational, with zero cycles of latency.
- ZERO_REG=1: rdN = 0 whenever raN = 0, regardless of we/wa/wd or bypass.
- Bypass (BYPASS=1): if we=1, wa==raN, ~reset, and not (ZERO_REG=1 and raN=0), then rdN = wd in the same cycle.
- Both read ports are independent. Both may address the same register, or the register being written, simultaneously with identical results.
- Width rules: no truncation or extension internally. All addresses are exactly ADDR_W bits, so every address is in range and no out-of-range case exists.
- No state machine; the only sequential state is the NREG x DATA_W storage array.

Decomposition:
- Shared package `regfile_pkg`:
  - default ADDR_W / DATA_W constants;
  - a function that computes NREG from ADDR_W;
  - a constant for the zero-register index (0).
- One sub-module is natural: `decoder_param`. It has parameter ADDR_W, inputs x and en, and a 2**ADDR_W one-hot output z with bit i = en & (x == i). It is reused wherever the existing fixed-width decoders are used.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with random contents loaded -> rd1=rd2=0 for every ra immediately; wr_sel=0 when we=0.
- Basic write/read (defaults): we=1, wa=5, wd=32'hDEADBEEF; next cycle ra1=5 -> rd1=32'hDEADBEEF. ra2=6 -> rd2=0.
- Zero register (ZERO_REG=1): we=1, wa=0, wd=32'hFFFFFFFF -> wr_sel=0 and rd1(ra1=0)=0 in the same cycle and all later cycles. With ZERO_REG=0 -> rd1=32'hFFFFFFFF after the edge.
- Bypass: reg 7 holds 32'h1. Drive we=1, wa=7, wd=32'h2, ra1=ra2=7 -> BYPASS=1 gives rd1=rd2=32'h2 before the edge; BYPASS=0 gives 32'h1 before the edge and 32'h2 after it.
- Decoder sweep with ADDR_W=3, DATA_W=8: write value i+16 to every address 0..7, then read all -> wr_sel is one-hot 8'b1 << i on each write and reads return i+16 (entry 0 returns 0 when ZERO_REG=1).
- Write during reset: reset=1 with we=1, wa=3, wd=8'hAA across an edge, release reset -> rd(ra=3)=0. The next edge with wd=8'h55 gives 8'h55.
